// File: rtl/conv_reg_seq.sv
// rtl/conv_reg_seq.sv - Frame-buffered 2-D convolution streaming one output pixel per beat.
// Optional build macro: CONV_RELU_EN clamps negative filter sums to zero before the output register.
module conv_reg_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int IMG_D      = 2,
  parameter int FILTER_W   = 3,
  parameter int FILTER_H   = 3,
  parameter int RESULT_D   = 4,
  parameter int STRIDE_W   = 1,
  parameter int STRIDE_H   = 1,
  parameter int PAD        = 0,
  localparam int RESULT_W  = (IMG_W + 2 * PAD - FILTER_W) / STRIDE_W + 1,
  localparam int RESULT_H  = (IMG_H + 2 * PAD - FILTER_H) / STRIDE_H + 1,
  localparam int RES_WIDTH = 4 * DATA_WIDTH,
  localparam int HW        = (RESULT_H > 1) ? $clog2(RESULT_H) : 1,
  localparam int WW        = (RESULT_W > 1) ? $clog2(RESULT_W) : 1,
  localparam int IMG_BITS  = IMG_D * IMG_H * IMG_W * DATA_WIDTH,
  localparam int FIL_BITS  = RESULT_D * IMG_D * FILTER_H * FILTER_W * DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [FIL_BITS-1:0]             fil,
  input  logic [IMG_BITS-1:0]             img_data_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [7:0]                      opaque_in,
  output logic [RESULT_D*RES_WIDTH-1:0]   result_data_out,
  output logic [HW-1:0]                   out_h,
  output logic [WW-1:0]                   out_w,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [7:0]                      opaque_out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [HW-1:0] H_LAST = HW'(RESULT_H - 1);
  localparam logic [WW-1:0] W_LAST = WW'(RESULT_W - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  state_t                        state, state_nx;
  logic [IMG_BITS-1:0]           img_r;
  logic [FIL_BITS-1:0]           fil_r;
  logic [HW-1:0]                 h;
  logic [WW-1:0]                 w;
  logic                          accept, load, last_px;
  logic [RESULT_D*RES_WIDTH-1:0] pixel;

  assign accept  = (state == IDLE) && in_valid;
  assign load    = (state == RUN) && (!out_valid || out_ready);
  assign last_px = (h == H_LAST) && (w == W_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:     if (load && last_px) state_nx = DRAIN;
      DRAIN:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame contents are only meaningful after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      img_r <= img_data_in;
      fil_r <= fil;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h               <= '0;
      w               <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      out_h           <= '0;
      out_w           <= '0;
      result_data_out <= '0;
      opaque_out      <= '0;
    end else if (accept) begin
      h          <= '0;
      w          <= '0;
      opaque_out <= opaque_in;
    end else if (load) begin
      result_data_out <= pixel;
      out_h           <= h;
      out_w           <= w;
      out_valid       <= 1'b1;
      out_last        <= last_px;
      if (w == W_LAST) begin
        w <= '0;
        h <= h + H_ONE;
      end else begin
        w <= w + W_ONE;
      end
    end else if (state == DRAIN && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Full window MAC for the current (h,w); taps falling in the padding border contribute nothing.
  always_comb begin
    int iy, ix;
    logic signed [DATA_WIDTH-1:0] pv, fv;
    logic signed [RES_WIDTH-1:0]  acc;
    pixel = '0;
    iy    = 0;
    ix    = 0;
    pv    = '0;
    fv    = '0;
    acc   = '0;
    for (int d = 0; d < RESULT_D; d++) begin
      acc = '0;
      for (int c = 0; c < IMG_D; c++) begin
        for (int y = 0; y < FILTER_H; y++) begin
          for (int x = 0; x < FILTER_W; x++) begin
            iy = int'(h) * STRIDE_H + y - PAD;
            ix = int'(w) * STRIDE_W + x - PAD;
            if (iy >= 0 && iy < IMG_H && ix >= 0 && ix < IMG_W) begin
              pv  = img_r[((c * IMG_H + iy) * IMG_W + ix) * DATA_WIDTH +: DATA_WIDTH];
              fv  = fil_r[(((d * IMG_D + c) * FILTER_H + y) * FILTER_W + x) * DATA_WIDTH +: DATA_WIDTH];
              acc = acc + RES_WIDTH'(pv) * RES_WIDTH'(fv);
            end
          end
        end
      end
`ifdef CONV_RELU_EN
      if (acc < 0) acc = '0;
`else
      acc = acc;
`endif
      pixel[d * RES_WIDTH +: RES_WIDTH] = acc;
    end
  end

endmodule

// File: doc/conv_reg_seq.md
CONV_REG_SEQ -- requirements
Module: conv_reg_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed element width of pixels and weights.
REQ-002 SHALL have parameters IMG_W 8, IMG_H 8, IMG_D 2: image width, height and channels.
REQ-003 SHALL have parameters FILTER_W 3, FILTER_H 3, RESULT_D 4: kernel width, kernel height and filter count.
REQ-004 SHALL have parameters STRIDE_W 1, STRIDE_H 1 and PAD 0 (zero-padding on every image border).
REQ-005 SHALL derive RESULT_W=(IMG_W+2*PAD-FILTER_W)/STRIDE_W+1, RESULT_H likewise, RES_WIDTH=4*DATA_WIDTH; these are not set manually.
REQ-006 SHALL have the port clk, input, 1 bit: the single clock.
REQ-007 SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have the port fil, input, RESULT_D*IMG_D*FILTER_H*FILTER_W*DATA_WIDTH bits; element (d,c,y,x) is at index ((d*IMG_D+c)*FILTER_H+y)*FILTER_W+x.
REQ-009 SHALL have the port img_data_in, input, IMG_D*IMG_H*IMG_W*DATA_WIDTH bits; element (c,h,w) is at index (c*IMG_H+h)*IMG_W+w.
REQ-010 SHALL have the ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the frame-load handshake.
REQ-011 SHALL have the port opaque_in, input, 8 bits: a user tag captured with the frame.
REQ-012 SHALL have the port result_data_out, output, RESULT_D*RES_WIDTH bits: one output pixel, with filter d at slice d.
REQ-013 SHALL have the ports out_h and out_w, outputs of $clog2 width (minimum 1): coordinates of the current pixel.
REQ-014 SHALL have the ports out_valid (output), out_ready (input) and out_last (output), each 1 bit: the result stream.
REQ-015 SHALL have the port opaque_out, output, 8 bits: the captured tag, held for the whole frame.

Function
REQ-016 SHALL use the states IDLE, RUN and DRAIN; in_ready SHALL be 1 only in IDLE.
REQ-017 SHALL, in IDLE when in_valid=1, latch img_data_in, fil and opaque_in, clear h and w to 0, and enter RUN on the same edge.
REQ-018 SHALL, in RUN, compute pixel (h,w) and load it into the output register on each edge where out_valid=0 or out_ready=1.
REQ-019 SHALL make the first out_valid appear one cycle after the accepting edge.
REQ-020 SHALL, with out_ready held at 1, deliver one pixel per cycle: RESULT_H*RESULT_W beats, in raster order with w fastest.
REQ-021 SHALL compute each pixel as result[d] = sum over c,y,x of img(c, h*STRIDE_H+y-PAD, w*STRIDE_W+x-PAD) * fil(d,c,y,x).
REQ-022 SHALL treat any image coordinate outside the image as 0.
REQ-023 SHALL perform all arithmetic signed, sign-extend operands to RES_WIDTH, and wrap modulo 2^RES_WIDTH with no saturation.
REQ-024 SHALL hold result_data_out, out_h, out_w, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL assert out_last only with pixel (RESULT_H-1, RESULT_W-1).
REQ-026 SHALL enter DRAIN after loading the last pixel, and return to IDLE on the edge where the last beat is consumed.
REQ-027 SHALL take a new frame no earlier than the cycle after the last beat is consumed.
REQ-028 SHALL produce a single beat with out_last=1 when RESULT_H=RESULT_W=1.

Reset
REQ-029 SHALL, while reset=0, force: state IDLE; out_valid, out_last, out_h, out_w, result_data_out and opaque_out to 0; in_ready to 1.
REQ-030 SHALL abandon any frame in progress when reset is asserted mid-frame; no further beats of that frame SHALL appear.
REQ-031 SHALL accept a new frame on the first edge after reset is deasserted.

Configuration
REQ-032 SHALL honour the macro CONV_RELU_EN: when defined, every result[d] below 0 is replaced by 0 before the output register.
REQ-033 SHALL, when CONV_RELU_EN is undefined, output raw signed sums; latency and handshake SHALL be identical in both builds.

Verification
REQ-034 Defaults, image all 1, filters all 1, out_ready=1 -> 36 beats, each result[d]=18, out_last on beat 36 at (5,5).
REQ-035 Defaults with PAD=1, same data -> 64 beats; (0,0)=8, (0,1)=12, (1,1)=18.
REQ-036 Image all -1, filters all 1 -> 32-bit results of -18 (0xFFFFFFEE); with CONV_RELU_EN defined -> 0.
REQ-037 out_ready toggling 1,0,0,1,... -> output held while stalled; no beat lost or duplicated; 36 beats total.
REQ-038 reset=0 asserted on beat 10, then a new frame with opaque_in=0xA5 -> out_valid=0 during reset; the new frame starts at (0,0) with opaque_out=0xA5.
REQ-039 in_valid held at 1 throughout -> the second frame is accepted only after the first frame's out_last beat is consumed.
